event_encoder: RTL and testbench



---
 rtl/event_enc_pkg.sv | 18 +
 rtl/rr_pick.sv | 47 ++++
 rtl/event_encoder.sv | 151 +++++++++++++++
 tb/tb_event_encoder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/event_enc_pkg.sv
// event_enc_pkg
// Shared definitions for the sequential 16-to-4 event encoder.
//   N_IN_DEFAULT   : default number of request lines
//   W_CODE_DEFAULT : default code width (log2 of N_IN_DEFAULT)
//   MERGE_W        : width of the saturating merge counter
//   state_t        : presentation state machine encoding
package event_enc_pkg;

    localparam int N_IN_DEFAULT   = 16;
    localparam int W_CODE_DEFAULT = 4;
    localparam int MERGE_W        = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational priority picker used by the event encoder.
//   vec     : candidate request vector
//   ptr     : index of the last accepted code (round-robin mode only)
//   rr_mode : 1 = search upward from ptr+1 with wrap, 0 = lowest index wins
//   idx     : selected index (meaningful only when found = 1)
//   found   : vec has at least one set bit
module rr_pick #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] ptr,
    input  logic         rr_mode,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [W-1:0] start;
    logic [W-1:0] k;
    logic [N-1:0] rotated;
    logic [W-1:0] offset;

    // Rotate the vector so the search start lands at bit 0, find the lowest
    // set bit, then add the start back. W-bit arithmetic wraps modulo N
    // because N is a power of two.
    always_comb begin
        start   = rr_mode ? (ptr + W'(1)) : '0;
        k       = '0;
        rotated = '0;
        for (int i = 0; i < N; i++) begin
            k          = W'(i) + start;
            rotated[i] = vec[k];
        end

        offset = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = W'(i);
            end
        end

        found = |vec;
        idx   = offset + start;
    end

endmodule

// File: rtl/event_encoder.sv
// event_encoder
// Captures single-cycle event pulses into a sticky pending vector and
// presents pending indices one at a time as a code over valid/ready.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   req       : event pulses, each set bit marks its index pending
//   flush     : synchronous clear of pending state and output
//   out_valid : out_code holds a pending index
//   out_code  : encoded index being presented
//   out_ready : consumer accepts out_code when out_valid is also high
//   pending   : registered sticky pending vector
//   merge_cnt : saturating count of req bits that hit an already-pending bit
module event_encoder
    import event_enc_pkg::*;
#(
    parameter int N_IN        = N_IN_DEFAULT,
    parameter int W_CODE      = W_CODE_DEFAULT,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_IN-1:0]     req,
    input  logic                flush,
    output logic                out_valid,
    output logic [W_CODE-1:0]   out_code,
    input  logic                out_ready,
    output logic [N_IN-1:0]     pending,
    output logic [MERGE_W-1:0]  merge_cnt
);

    localparam int   CNT_W     = $clog2(N_IN + 1);
    localparam int   SUM_W     = MERGE_W + CNT_W;
    localparam int   MERGE_MAX = (2 ** MERGE_W) - 1;
    localparam logic RR_MODE   = (ROUND_ROBIN != 0);

    state_t              state;
    logic [W_CODE-1:0]   ptr;

    logic                accept;
    logic [N_IN-1:0]     code_onehot;
    logic [N_IN-1:0]     clr_mask;
    logic [N_IN-1:0]     kept;
    logic [N_IN-1:0]     pending_next;
    logic [N_IN-1:0]     merged;
    logic [N_IN-1:0]     cand;
    logic [CNT_W-1:0]    merge_inc;
    logic [SUM_W-1:0]    merge_sum;
    logic [MERGE_W-1:0]  merge_next;

    logic [W_CODE-1:0]   load_idx;
    logic                load_found;
    logic [W_CODE-1:0]   reload_idx;
    logic                reload_found;

    // Pending update and merge counting. A bit being accepted this edge is
    // cleared first, so a req on that same bit counts as a fresh event and
    // not as a merge.
    always_comb begin
        accept       = out_valid & out_ready;
        code_onehot  = {{(N_IN-1){1'b0}}, 1'b1} << out_code;
        clr_mask     = accept ? code_onehot : '0;
        kept         = pending & ~clr_mask;
        pending_next = kept | req;
        merged       = req & kept;
        cand         = pending & ~code_onehot;

        merge_inc = '0;
        for (int i = 0; i < N_IN; i++) begin
            merge_inc = merge_inc + CNT_W'(merged[i]);
        end

        merge_sum = SUM_W'(merge_cnt) + SUM_W'(merge_inc);
        if (merge_sum > SUM_W'(MERGE_MAX)) begin
            merge_next = '1;
        end else begin
            merge_next = merge_sum[MERGE_W-1:0];
        end
    end

    // First presentation out of IDLE searches from the last accepted index.
    rr_pick #(
        .N (N_IN),
        .W (W_CODE)
    ) u_load_pick (
        .vec     (pending),
        .ptr     (ptr),
        .rr_mode (RR_MODE),
        .idx     (load_idx),
        .found   (load_found)
    );

    // Back-to-back reload searches from the code being accepted right now,
    // which is the value ptr takes at this same edge. Same-cycle req bits
    // are excluded from cand and get picked up on a later cycle.
    rr_pick #(
        .N (N_IN),
        .W (W_CODE)
    ) u_reload_pick (
        .vec     (cand),
        .ptr     (out_code),
        .rr_mode (RR_MODE),
        .idx     (reload_idx),
        .found   (reload_found)
    );

    // State machine and all registered outputs. flush overrides accept and
    // req but leaves the round-robin pointer and out_code alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= '0;
            merge_cnt <= '0;
            out_valid <= 1'b0;
            out_code  <= '0;
            ptr       <= W_CODE'(N_IN - 1);
        end else if (flush) begin
            state     <= IDLE;
            pending   <= '0;
            merge_cnt <= '0;
            out_valid <= 1'b0;
        end else begin
            pending   <= pending_next;
            merge_cnt <= merge_next;
            case (state)
                IDLE: begin
                    if (load_found) begin
                        out_code  <= load_idx;
                        out_valid <= 1'b1;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (accept) begin
                        ptr <= out_code;
                        if (reload_found) begin
                            out_code <= reload_idx;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_event_encoder.sv
// tb_event_encoder
// Directed bench for event_encoder: one round-robin instance and one
// fixed-priority instance share the same stimulus.
module tb_event_encoder;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        flush;
    logic        out_ready;

    logic        rr_valid;
    logic [3:0]  rr_code;
    logic [15:0] rr_pending;
    logic [7:0]  rr_merge;

    logic        fp_valid;
    logic [3:0]  fp_code;
    logic [15:0] fp_pending;
    logic [7:0]  fp_merge;

    int vectors;
    int miscompares;

    event_encoder #(
        .N_IN        (16),
        .W_CODE      (4),
        .ROUND_ROBIN (1)
    ) dut_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .flush     (flush),
        .out_valid (rr_valid),
        .out_code  (rr_code),
        .out_ready (out_ready),
        .pending   (rr_pending),
        .merge_cnt (rr_merge)
    );

    event_encoder #(
        .N_IN        (16),
        .W_CODE      (4),
        .ROUND_ROBIN (0)
    ) dut_fp (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .flush     (flush),
        .out_valid (fp_valid),
        .out_code  (fp_code),
        .out_ready (out_ready),
        .pending   (fp_pending),
        .merge_cnt (fp_merge)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        req = 16'h0010;
        tick();
        req = '0;
        tick();
        vectors++;
        if (rr_valid !== 1'b1 || rr_code !== 4'd4) begin
            miscompares++;
            $display("[TB] FAIL reset_pre_present: got valid=%b code=%0d expected valid=1 code=4", rr_valid, rr_code);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (rr_valid !== 1'b0 || rr_pending !== 16'h0000 || rr_merge !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_async: got valid=%b pending=%h merge=%0d expected 0/0000/0", rr_valid, rr_pending, rr_merge);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req   = 16'h0001;
        tick();
        req = '0;
        vectors++;
        if (rr_valid !== 1'b0 || rr_pending !== 16'h0001) begin
            miscompares++;
            $display("[TB] FAIL reset_latency_e0: got valid=%b pending=%h expected valid=0 pending=0001", rr_valid, rr_pending);
        end
        tick();
        vectors++;
        if (rr_valid !== 1'b1 || rr_code !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_latency_e1: got valid=%b code=%0d expected valid=1 code=0", rr_valid, rr_code);
        end
    endtask

    task automatic test_rr_burst();
        logic [3:0] exp_codes [4];
        exp_codes[0] = 4'd0;
        exp_codes[1] = 4'd5;
        exp_codes[2] = 4'd10;
        exp_codes[3] = 4'd15;
        do_reset();
        out_ready = 1'b1;
        req = 16'h8421;
        tick();
        req = '0;
        vectors++;
        if (rr_valid !== 1'b0 || rr_pending !== 16'h8421) begin
            miscompares++;
            $display("[TB] FAIL burst_capture: got valid=%b pending=%h expected valid=0 pending=8421", rr_valid, rr_pending);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (rr_valid !== 1'b1 || rr_code !== exp_codes[i]) begin
                miscompares++;
                $display("[TB] FAIL burst_code%0d: got valid=%b code=%0d expected valid=1 code=%0d", i, rr_valid, rr_code, exp_codes[i]);
            end
        end
        tick();
        vectors++;
        if (rr_valid !== 1'b0 || rr_pending !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL burst_drain: got valid=%b pending=%h expected valid=0 pending=0000", rr_valid, rr_pending);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 16'h0006;
        tick();
        req = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (rr_valid !== 1'b1 || rr_code !== 4'd1) begin
                miscompares++;
                $display("[TB] FAIL hold_cycle%0d: got valid=%b code=%0d expected valid=1 code=1", i, rr_valid, rr_code);
            end
            tick();
        end
        out_ready = 1'b1;
        vectors++;
        if (rr_valid !== 1'b1 || rr_code !== 4'd1) begin
            miscompares++;
            $display("[TB] FAIL hold_release: got valid=%b code=%0d expected valid=1 code=1", rr_valid, rr_code);
        end
        tick();
        vectors++;
        if (rr_valid !== 1'b1 || rr_code !== 4'd2) begin
            miscompares++;
            $display("[TB] FAIL hold_second: got valid=%b code=%0d expected valid=1 code=2", rr_valid, rr_code);
        end
        tick();
        vectors++;
        if (rr_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL hold_drain: got valid=%b expected valid=0", rr_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_rerequest();
        do_reset();
        req = 16'h0028;
        tick();
        req = '0;
        tick();
        vectors++;
        if (rr_valid !== 1'b1 || rr_code !== 4'd3) begin
            miscompares++;
            $display("[TB] FAIL rereq_first: got valid=%b code=%0d expected valid=1 code=3", rr_valid, rr_code);
        end
        out_ready = 1'b1;
        req = 16'h0008;
        tick();
        req = '0;
        vectors++;
        if (rr_pending !== 16'h0028 || rr_merge !== 8'd0 || rr_code !== 4'd5) begin
            miscompares++;
            $display("[TB] FAIL rereq_accept_edge: got pending=%h merge=%0d code=%0d expected 0028/0/5", rr_pending, rr_merge, rr_code);
        end
        tick();
        vectors++;
        if (rr_valid !== 1'b1 || rr_code !== 4'd3) begin
            miscompares++;
            $display("[TB] FAIL rereq_again: got valid=%b code=%0d expected valid=1 code=3", rr_valid, rr_code);
        end
        tick();
        vectors++;
        if (rr_valid !== 1'b0 || rr_pending !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL rereq_drain: got valid=%b pending=%h expected valid=0 pending=0000", rr_valid, rr_pending);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_merge_saturate();
        do_reset();
        req = 16'h0001;
        repeat (10) tick();
        vectors++;
        if (rr_merge !== 8'd9) begin
            miscompares++;
            $display("[TB] FAIL merge_partial: got %0d expected 9", rr_merge);
        end
        repeat (290) tick();
        vectors++;
        if (rr_merge !== 8'd255 || rr_valid !== 1'b1 || rr_code !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL merge_saturate: got merge=%0d valid=%b code=%0d expected 255/1/0", rr_merge, rr_valid, rr_code);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        req   = '0;
        vectors++;
        if (rr_merge !== 8'd0 || rr_valid !== 1'b0 || rr_pending !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL flush_clear: got merge=%0d valid=%b pending=%h expected 0/0/0000", rr_merge, rr_valid, rr_pending);
        end
        tick();
        vectors++;
        if (rr_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_req_dropped: got valid=%b expected valid=0", rr_valid);
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        req = 16'h0102;
        tick();
        req = '0;
        tick();
        vectors++;
        if (fp_valid !== 1'b1 || fp_code !== 4'd1) begin
            miscompares++;
            $display("[TB] FAIL fixed_first: got valid=%b code=%0d expected valid=1 code=1", fp_valid, fp_code);
        end
        req = 16'h0001;
        tick();
        req = '0;
        vectors++;
        if (fp_pending !== 16'h0103 || fp_code !== 4'd1) begin
            miscompares++;
            $display("[TB] FAIL fixed_inject: got pending=%h code=%0d expected 0103/1", fp_pending, fp_code);
        end
        out_ready = 1'b1;
        tick();
        vectors++;
        if (fp_code !== 4'd0 || fp_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL fixed_low_wins: got valid=%b code=%0d expected valid=1 code=0", fp_valid, fp_code);
        end
        vectors++;
        if (rr_code !== 4'd8 || rr_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rr_contrast: got valid=%b code=%0d expected valid=1 code=8", rr_valid, rr_code);
        end
        tick();
        vectors++;
        if (fp_code !== 4'd8 || fp_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL fixed_then_8: got valid=%b code=%0d expected valid=1 code=8", fp_valid, fp_code);
        end
        tick();
        vectors++;
        if (fp_valid !== 1'b0 || fp_pending !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL fixed_drain: got valid=%b pending=%h expected valid=0 pending=0000", fp_valid, fp_pending);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        req         = '0;
        flush       = 1'b0;
        out_ready   = 1'b0;

        test_reset();
        test_rr_burst();
        test_backpressure();
        test_rerequest();
        test_merge_saturate();
        test_fixed_priority();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
